// File: rtl/quantize_zigzag_88_if.sv
// Output stream bundle of quantize_zigzag_88: one quantised coefficient per beat, valid/ready handshake.
interface quantize_zigzag_88_if #(
    parameter int OUT_WIDTH = 12
);
    logic                        out_valid;
    logic                        out_ready;
    logic signed [OUT_WIDTH-1:0] out_data;
    logic [5:0]                  out_index;
    logic                        out_last;

    modport master (output out_valid, out_data, out_index, out_last, input out_ready);
    modport slave  (input out_valid, out_data, out_index, out_last, output out_ready);
endinterface

// File: rtl/quantize_zigzag_88.sv
// Zigzag read-out, reciprocal quantisation and output buffering of one 8x8 DCT block per start pulse.
// Build option: JFPJC_QZ_ROUND_EN selects round-half-away-from-zero; otherwise truncate toward zero.
module quantize_zigzag_88 #(
    parameter int COEF_FRAC_BITS = 4,
    parameter int OUT_WIDTH      = 12,
    parameter int FIFO_DEPTH     = 2
) (
    input  logic                 clock,
    input  logic                 nreset,
    input  logic                 start,
    output logic [5:0]           coef_read_addr,
    input  logic signed [15:0]   coef_read_data,
    output logic [5:0]           qtab_read_addr,
    input  logic [15:0]          qtab_read_data,
    output logic                 busy,
    output logic                 done,
    quantize_zigzag_88_if.master out_if
);
    localparam int SH = 15 + COEF_FRAC_BITS;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [32:0] MAXV = 33'((1 << (OUT_WIDTH - 1)) - 1);

    // Natural (row-major) position of the k-th coefficient in JPEG zigzag order.
    localparam logic [5:0] ZZ [64] = '{
         0,  1,  8, 16,  9,  2,  3, 10,
        17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34,
        27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36,
        29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46,
        53, 60, 61, 54, 47, 55, 62, 63
    };

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    typedef struct packed {
        logic signed [OUT_WIDTH-1:0] data;
        logic [5:0]                  idx;
        logic                        last;
    } beat_t;

    state_t             r_state, w_next;
    logic [5:0]         r_k;
    logic [5:0]         r_kp;
    logic               r_s1_vld;
    logic               r_done;
    beat_t              r_mem [FIFO_DEPTH];
    logic [AW-1:0]      r_wp, r_rp;
    logic [CW-1:0]      r_cnt;

    logic               w_issue, w_push, w_pop;
    logic [CW:0]        w_pending;
    beat_t              w_head, w_beat;

    logic signed [32:0] w_prod;
    logic               w_neg;
    logic [32:0]        w_mag, w_mag_r, w_q;
    logic [OUT_WIDTH-1:0] w_sat;
    logic signed [OUT_WIDTH-1:0] w_res;

    // Addresses come straight from k so the EBR sees them in the issue cycle.
    assign coef_read_addr = ZZ[r_k];
    assign qtab_read_addr = ZZ[r_k];

    assign w_push = r_s1_vld;
    assign w_pop  = (r_cnt != '0) && out_if.out_ready;
    assign w_head = r_mem[r_rp];

    // Entries still owed to the buffer after this edge; a new read must fit on top of them
    // even if the consumer stalls from now on.
    assign w_pending = {1'b0, r_cnt} + {{CW{1'b0}}, w_push} - {{CW{1'b0}}, w_pop};
    assign w_issue   = (r_state == RUN) && (w_pending < (CW+1)'(FIFO_DEPTH));

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = RUN;
            RUN:     if (w_issue && r_k == 6'd63) w_next = DRAIN;
            DRAIN:   if (w_pop && w_head.last) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_prod = 33'(coef_read_data) * 33'($signed({1'b0, qtab_read_data}));
        w_neg  = w_prod[32];
        w_mag  = w_neg ? 33'(-w_prod) : 33'(w_prod);
`ifdef JFPJC_QZ_ROUND_EN
        w_mag_r = w_mag + (33'd1 << (SH - 1));
`else
        w_mag_r = w_mag;
`endif
        w_q   = w_mag_r >> SH;
        w_sat = (w_q > MAXV) ? MAXV[OUT_WIDTH-1:0] : w_q[OUT_WIDTH-1:0];
        w_res = w_neg ? -$signed(w_sat) : $signed(w_sat);
        w_beat      = '0;
        w_beat.data = w_res;
        w_beat.idx  = r_kp;
        w_beat.last = (r_kp == 6'd63);
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_state  <= IDLE;
            r_k      <= '0;
            r_kp     <= '0;
            r_s1_vld <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_done   <= (r_state == DRAIN) && w_pop && w_head.last;
            r_s1_vld <= w_issue;
            if (r_state == IDLE && start)
                r_k <= '0;
            else if (w_issue)
                r_k <= r_k + 6'd1;
            if (w_issue)
                r_kp <= r_k;
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                r_mem[i] <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wp] <= w_beat;
                r_wp        <= r_wp + AW'(1);
            end
            if (w_pop)
                r_rp <= r_rp + AW'(1);
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        end
    end

    assign busy = (r_state != IDLE);
    assign done = r_done;

    // Outputs read as zero whenever the buffer is empty.
    assign out_if.out_valid = (r_cnt != '0);
    assign out_if.out_data  = out_if.out_valid ? w_head.data : '0;
    assign out_if.out_index = out_if.out_valid ? w_head.idx  : '0;
    assign out_if.out_last  = out_if.out_valid ? w_head.last : 1'b0;
endmodule
